row_scan_ctrl: RTL and testbench
================================

Name: row_scan_ctrl

Overview:
- Sequencer for the 16:1 single-bit pixel mux used in the binarized-image segmentation path.
- Accepts one 16-bit binarized row word and holds it on the mux data inputs.
- Steps the 4-bit mux select 0..15 and streams the selected pixel bits out under valid/ready flow control.
- At end of row, reports ink statistics (ones count, first/last set column) to the bounding-box logic.

Parameters:
IWIDTH, 16, row word width; fixed at 16 to match the 4-bit mux select; other values unsupported.
CWIDTH, 5, width of ones_count; must satisfy 2^CWIDTH > IWIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  row word available.
in_ready  output  1  controller can accept a row word (IDLE only).
in_row  input  IWIDTH  binarized row; bit i = column i.
flush  input  1  synchronous abort of the current row.
mux_in  output  IWIDTH  registered row word driven to the external mux data input.
mux_sel  output  4  registered select driven to the external mux.
mux_bit  input  1  external mux output (combinational from mux_in/mux_sel).
bit_valid  output  1  bit_out is valid.
bit_ready  input  1  downstream accepts the bit.
bit_out  output  1  current pixel; equals mux_bit.
bit_idx  output  4  column of bit_out; equals mux_sel.
bit_last  output  1  high with bit_valid when bit_idx==15.
done  output  1  one-cycle pulse: row complete, statistics valid.
ones_count  output  CWIDTH  number of set pixels in the last completed row.
first_idx  output  4  lowest set column of the last completed row.
last_idx  output  4  highest set column of the last completed row.
row_empty  output  1  last completed row had no set pixels.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mux_in=0, mux_sel=0, bit_valid=0, done=0.
  - ones_count=0, first_idx=0, last_idx=0, row_empty=1.
  - in_ready=1 once rst_n is released.
  - Reset mid-row discards the row; no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1, bit_valid=0.
  - On in_valid&in_ready: mux_in<=in_row, mux_sel<=0, clear the running accumulators, go to SCAN.
  - The first bit is presented in the cycle after the load handshake.
- SCAN:
  - in_ready=0, bit_valid=1.
  - bit_out=mux_bit, bit_idx=mux_sel, bit_last=(mux_sel==15).
  - On bit_valid&bit_ready with bit_out=1:
    - running count increments.
    - running first is captured if no prior 1 in this row.
    - running last <= mux_sel.
  - On a handshake with mux_sel<15: mux_sel increments.
  - On a handshake with mux_sel==15: go to DONE; mux_sel holds at 15.
  - No handshake (bit_ready=0): mux_sel, bit_out and accumulators hold; bit_valid stays high.
- DONE (exactly one cycle):
  - done=1.
  - Registered outputs ones_count/first_idx/last_idx/row_empty are updated from the accumulators on SCAN->DONE.
  - Next state is IDLE; in_ready=0 during DONE.
  - Statistics hold until the next DONE or reset.
- Minimum row time: 1 (load) + 16 (bits) + 1 (DONE) = 18 cycles at full throughput; the next load can occur in the cycle after DONE.
- row_empty=1 implies first_idx=last_idx=0 and ones_count=0.
- flush:
  - In SCAN or DONE: next state is IDLE, bit_valid=0, no done pulse; previous statistics retained.
  - flush in DONE suppresses nothing already pulsed; the transition is unchanged.
  - Ignored in IDLE; flush has priority over a simultaneous load handshake, which is not accepted (in_ready is forced 0 while flush=1).
- in_row is sampled only on the load handshake; changes during SCAN have no effect.

Test Plan:
- Reset, then load in_row=16'h8001 with bit_ready=1 -> bits 1,0x14,1 on consecutive cycles, bit_last at idx 15, done 1 cycle later; ones_count=2, first_idx=0, last_idx=15, row_empty=0.
- Load 16'h0000 -> 16 zero bits; ones_count=0, first_idx=0, last_idx=0, row_empty=1.
- Load 16'h00F0, bit_ready toggling 1/0 every cycle -> each bit held while stalled, sel advances only on handshakes; done 33 cycles after load; ones_count=4, first_idx=4, last_idx=7.
- Load 16'hFFFF, assert flush at bit_idx=5 -> bit_valid low next cycle, no done pulse, stats unchanged from the prior row, in_ready=1 in IDLE.
- Assert rst_n=0 mid-row at bit_idx=9 -> all outputs immediately at reset values; reload 16'h0400 -> ones_count=1, first_idx=last_idx=10.
- Back-to-back loads with in_valid held high -> second row accepted in the cycle after done; in_ready low throughout SCAN and DONE.

Source files
------------

// File: rtl/row_scan_ctrl.sv
// row_scan_ctrl: sequencer for a 16:1 single-bit pixel mux.
// It holds one binarized row word on the mux data inputs and steps the select
// from 0 to 15. The selected pixels stream out under valid/ready flow control.
// At the end of each row it publishes the ink statistics: the ones count and
// the first and last set columns.
module row_scan_ctrl #(
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_row,
  input  logic              flush,
  output logic [IWIDTH-1:0] mux_in,
  output logic [3:0]        mux_sel,
  input  logic              mux_bit,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic [3:0]        bit_idx,
  output logic              bit_last,
  output logic              done,
  output logic [CWIDTH-1:0] ones_count,
  output logic [3:0]        first_idx,
  output logic [3:0]        last_idx,
  output logic              row_empty
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t            state;

  // Running statistics for the row currently being scanned.
  logic [CWIDTH-1:0] acc_count;
  logic [3:0]        acc_first;
  logic [3:0]        acc_last;
  logic              acc_seen;

  // Accumulator values that include the bit being accepted this cycle. These
  // values also feed the published statistics on the final column.
  logic [CWIDTH-1:0] count_nx;
  logic [3:0]        first_nx;
  logic [3:0]        last_nx;
  logic              seen_nx;
  logic              xfer;
  logic              hit;

  // A flush blocks a load in the same cycle. The controller accepts rows only in IDLE.
  assign in_ready = (state == ST_IDLE) && !flush;

  // The pixel stream is the external mux output. Its column is the select now being driven.
  assign bit_out  = mux_bit;
  assign bit_idx  = mux_sel;
  assign bit_last = bit_valid && (mux_sel == 4'd15);

  // Fold the pixel being accepted into the running statistics.
  always_comb begin
    // NOTE: every variable gets a default value first, so no path leaves one
    // unassigned. An unassigned path would infer a latch.
    xfer     = bit_valid && bit_ready && !flush;
    hit      = xfer && mux_bit;
    count_nx = acc_count;
    first_nx = acc_first;
    last_nx  = acc_last;
    seen_nx  = acc_seen;
    if (hit) begin
      count_nx = acc_count + CWIDTH'(1);
      last_nx  = mux_sel;
      seen_nx  = 1'b1;
      if (!acc_seen) begin
        first_nx = mux_sel;
      end
    end
  end

  // The row FSM holds the mux operands, the accumulators and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use only non-blocking assignments. All flops then
    // update together from values sampled before the edge.
    if (!rst_n) begin
      state      <= ST_IDLE;
      mux_in     <= '0;
      mux_sel    <= 4'd0;
      bit_valid  <= 1'b0;
      done       <= 1'b0;
      acc_count  <= '0;
      acc_first  <= 4'd0;
      acc_last   <= 4'd0;
      acc_seen   <= 1'b0;
      ones_count <= '0;
      first_idx  <= 4'd0;
      last_idx   <= 4'd0;
      row_empty  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            mux_in    <= in_row;
            mux_sel   <= 4'd0;
            acc_count <= '0;
            acc_first <= 4'd0;
            acc_last  <= 4'd0;
            acc_seen  <= 1'b0;
            bit_valid <= 1'b1;
            state     <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (flush) begin
            // Abandon the row. The statistics from the previous row stay published.
            bit_valid <= 1'b0;
            state     <= ST_IDLE;
          end else if (xfer) begin
            acc_count <= count_nx;
            acc_first <= first_nx;
            acc_last  <= last_nx;
            acc_seen  <= seen_nx;
            if (mux_sel == 4'd15) begin
              bit_valid  <= 1'b0;
              done       <= 1'b1;
              ones_count <= count_nx;
              first_idx  <= first_nx;
              last_idx   <= last_nx;
              row_empty  <= !seen_nx;
              state      <= ST_DONE;
            end else begin
              mux_sel <= mux_sel + 4'd1;
            end
          end
        end

        ST_DONE: begin
          // DONE lasts one cycle, whether or not flush is asserted.
          state <= ST_IDLE;
        end

        default: begin
          bit_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_scan_ctrl.sv
// tb_row_scan_ctrl: randomized self-checking bench for row_scan_ctrl.
// The external 16:1 mux is modelled as a plain array index. The expected row
// statistics come from a direct scan of the row word.
module tb_row_scan_ctrl;

  localparam int IWIDTH = 16;
  localparam int CWIDTH = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IWIDTH-1:0] in_row = '0;
  logic              flush = 1'b0;
  logic [IWIDTH-1:0] mux_in;
  logic [3:0]        mux_sel;
  logic              mux_bit;
  logic              bit_valid;
  logic              bit_ready = 1'b0;
  logic              bit_out;
  logic [3:0]        bit_idx;
  logic              bit_last;
  logic              done;
  logic [CWIDTH-1:0] ones_count;
  logic [3:0]        first_idx;
  logic [3:0]        last_idx;
  logic              row_empty;

  int checks = 0;
  int errors = 0;

  // Statistics of the last completed row, as expected by the bench.
  logic [CWIDTH-1:0] prev_cnt   = '0;
  logic [3:0]        prev_first = 4'd0;
  logic [3:0]        prev_last  = 4'd0;
  logic              prev_empty = 1'b1;

  row_scan_ctrl #(.IWIDTH(IWIDTH), .CWIDTH(CWIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .flush      (flush),
    .mux_in     (mux_in),
    .mux_sel    (mux_sel),
    .mux_bit    (mux_bit),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .bit_out    (bit_out),
    .bit_idx    (bit_idx),
    .bit_last   (bit_last),
    .done       (done),
    .ones_count (ones_count),
    .first_idx  (first_idx),
    .last_idx   (last_idx),
    .row_empty  (row_empty)
  );

  // External combinational pixel mux.
  assign mux_bit = mux_in[mux_sel];

  always #5 clk = ~clk;

  // Reference statistics: count the set pixels and find the lowest and highest set columns.
  task automatic ref_stats(input logic [15:0] row, output logic [CWIDTH-1:0] c,
                           output logic [3:0] f, output logic [3:0] l, output logic e);
    c = '0; f = 4'd0; l = 4'd0; e = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (row[i]) begin
        if (e) f = 4'(i);
        l = 4'(i);
        c = c + CWIDTH'(1);
        e = 1'b0;
      end
    end
  endtask

  // Load a row and stream its 16 pixels. Mode 0 gives full throughput, mode 1
  // toggles bit_ready starting low, and mode 2 drives a random bit_ready.
  // When hold is set, in_valid stays high after DONE so the next row can load back to back.
  task automatic do_row(input logic [15:0] row, input int mode, input bit hold);
    logic [28:0]       got, exp;
    logic [CWIDTH-1:0] ec;
    logic [3:0]        ef, el;
    logic              ee, r;
    int                idx, cyc;
    @(negedge clk);
    in_valid = 1'b1; in_row = row; flush = 1'b0; bit_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready: got %b want 1", in_ready);
    end
    idx = 0; cyc = 0;
    while (idx < 16) begin
      @(negedge clk);
      cyc++;
      if (!hold) in_valid = 1'b0;
      in_row = 16'($urandom);
      exp = {1'b1, 4'(idx), row[idx], (idx == 15), 1'b0, 1'b0, 4'(idx), row};
      got = {bit_valid, bit_idx, bit_out, bit_last, in_ready, done, mux_sel, mux_in};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL scan_bit row=%h idx=%0d: got {valid,idx,bit,last,in_rdy,done,sel,mux_in}=%h want %h",
                 row, idx, got, exp);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bit_ready = r;
      if (r) idx++;
    end
    @(negedge clk);
    bit_ready = 1'($urandom_range(0, 1));
    ref_stats(row, ec, ef, el, ee);
    got = {16'h0, done, bit_valid, in_ready, ones_count, first_idx, last_idx, row_empty};
    exp = {16'h0, 1'b1, 1'b0, 1'b0, ec, ef, el, ee};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL done_stats row=%h: got {done,valid,in_rdy,cnt,first,last,empty}=%h want %h",
               row, got, exp);
    end
    prev_cnt = ec; prev_first = ef; prev_last = el; prev_empty = ee;
    if (!hold) begin
      in_valid = 1'b0;
      @(negedge clk);
      got = {16'h0, done, bit_valid, in_ready, ones_count, first_idx, last_idx, row_empty};
      exp = {16'h0, 1'b0, 1'b0, 1'b1, prev_cnt, prev_first, prev_last, prev_empty};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL idle_hold row=%h: got %h want %h", row, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [28:0] got, exp;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    got = {bit_valid, done, mux_sel, mux_in, ones_count, first_idx, last_idx, row_empty};
    exp = {1'b0, 1'b0, 4'd0, 16'h0, 5'd0, 4'd0, 4'd0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_state: got %h want %h", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    do_row(16'h8001, 0, 1'b0);
    do_row(16'h0000, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_row(16'h00F0, 1, 1'b0);
    for (int n = 0; n < 6; n++) do_row(16'($urandom), 2, 1'b0);
  endtask

  task automatic test_flush();
    logic [18:0] got, exp;
    @(negedge clk);
    in_valid = 1'b1; in_row = 16'hFFFF; bit_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      bit_ready = 1'b1;
    end
    // The last iteration above leaves column 5 on the output. Flush it, and
    // request a load that must not be taken.
    checks++;
    if (bit_idx !== 4'd5) begin
      errors++; $display("FAIL flush_pos: got idx %0d want 5", bit_idx);
    end
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    got = {done, bit_valid, in_ready, ones_count, first_idx, last_idx, row_empty};
    exp = {1'b0, 1'b0, 1'b1, prev_cnt, prev_first, prev_last, prev_empty};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL flush_scan: got %h want %h", got, exp);
    end
    // In IDLE, flush has priority over a load request.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({bit_valid, done} !== 2'b00) begin
      errors++; $display("FAIL flush_idle_load: got valid,done=%b want 00", {bit_valid, done});
    end
  endtask

  task automatic test_mid_reset();
    logic [28:0] got, exp;
    @(negedge clk);
    in_valid = 1'b1; in_row = 16'hA5C3; bit_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      bit_ready = 1'b1;
    end
    checks++;
    if (bit_idx !== 4'd9) begin
      errors++; $display("FAIL reset_pos: got idx %0d want 9", bit_idx);
    end
    rst_n = 1'b0;
    #1;
    got = {bit_valid, done, mux_sel, mux_in, ones_count, first_idx, last_idx, row_empty};
    exp = {1'b0, 1'b0, 4'd0, 16'h0, 5'd0, 4'd0, 4'd0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL mid_reset_state: got %h want %h", got, exp);
    end
    prev_cnt = '0; prev_first = 4'd0; prev_last = 4'd0; prev_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; bit_ready = 1'b0;
    do_row(16'h0400, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_row(16'($urandom), 0, 1'b1);
    do_row(16'($urandom), 0, 1'b1);
    do_row(16'($urandom), 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
